serial_addsub: RTL and testbench
================================

// Module: serial_addsub
//
// PURPOSE
// Parametrised multi-cycle adder/subtractor: the sequential successor to the lab's
// combinational 32-bit subtractor. Processes DIGIT bits per clock, LSB digit first,
// with a start/done handshake and carry/overflow/zero flags. It sits beside the ALU
// datapath and trades latency for area. One cycle per digit, one adder slice.
//
// PARAMETERS
// WIDTH  32  operand/result width in bits; must be a multiple of DIGIT
// DIGIT   8  bits processed per cycle; N = WIDTH/DIGIT digit cycles per operation
//
// PORTS
// clk       in   1      clock; all state updates on rising edge
// reset     in   1      synchronous, active-high reset
// start     in   1      request; accepted only when ready=1
// op        in   1      0 = add (a+b), 1 = subtract (a-b); sampled with start
// a         in   WIDTH  operand A; sampled with start
// b         in   WIDTH  operand B; sampled with start
// ready     out  1      high in IDLE and DONE; start is accepted only then
// done      out  1      one-cycle pulse: result and flags valid
// result    out  WIDTH  sum/difference; held until the next accepted start
// carryout  out  1      add: carry out of MSB; sub: 1 = no borrow (a >= b unsigned)
// overflow  out  1      signed overflow of the two's-complement operation
// zero      out  1      result == 0
//
// BEHAVIOUR
// - Reset: state=IDLE; ready=1; done=0; result, carryout, overflow and zero all 0.
//   Reset wins over start and aborts any operation in flight. No done pulse follows.
// - States: IDLE -> BUSY on accepted start.
//   BUSY -> BUSY while digit count < N-1. BUSY -> DONE after digit N-1.
//   DONE -> IDLE next cycle, or DONE -> BUSY if start is asserted in DONE (back-to-back).
// - On accept: latch a, op, and b_eff = op ? ~b : b. Set carry register = op.
//   Clear digit count and the result shift register.
// - Each BUSY cycle: digit i = a[i*DIGIT +: DIGIT] + b_eff[i*DIGIT +: DIGIT] + carry.
//   Write digit i into result[i*DIGIT +: DIGIT]; update carry.
// - Latency: start sampled at edge 0; done=1 in the cycle following edge N.
//   Minimum initiation interval = N+1 cycles.
// - Flags update with the final digit:
//   carryout = final carry.
//   overflow = carry into MSB XOR carry out of MSB.
//   zero = (result == 0). Flags are held with result.
// - result is updated digit-by-digit during BUSY; it is architecturally valid only
//   while done=1 and thereafter until the next accepted start.
// - start in BUSY is ignored: no queueing, operands are not re-sampled.
// - Operand inputs may change freely after acceptance.
// - Wrap-around: results are modulo 2^WIDTH; no saturation.
// - DIGIT == WIDTH is legal: N=1, done two cycles after start.
//
// STRUCTURE
// - Shared include addsub_defs.vh: state encodings IDLE/BUSY/DONE and OP_ADD=0 / OP_SUB=1.
// - Sub-module addsub_digit #(DIGIT): combinational DIGIT-bit ripple slice.
//   Inputs: x, y, cin. Outputs: sum, cout, and the carry into the slice MSB
//   (needed for overflow). Instantiated once.
// - Top level: FSM, digit counter ($clog2(N) bits, minimum 1), operand registers,
//   result register, flag registers.
//
// TESTING (WIDTH=32, DIGIT=8 unless noted)
// 1. sub a=8, b=9 -> done at cycle 5; result=32'hFFFFFFFF, carryout=0, overflow=0, zero=0.
// 2. sub a=11, b=1 -> result=10, carryout=1. add a=27, b=3 -> result=30, carryout=0.
// 3. add a=32'h7FFFFFFF, b=1 -> result=32'h80000000, overflow=1. sub a=5, b=5 -> result=0,
//    zero=1, carryout=1.
// 4. Assert start again 2 cycles into BUSY with different operands -> ignored; first result
//    returned; done pulses exactly once. Then start asserted during DONE -> accepted, ready
//    drops next cycle.
// 5. reset asserted mid-BUSY -> next cycle IDLE, ready=1, result=0, no done pulse; a fresh
//    start then completes normally.
// 6. DIGIT=1: sub a=11, b=2049 -> done 33 cycles after start, result=32'hFFFFF80A,
//    carryout=0. Random a/b/op checked against a reference model for DIGIT in {1,4,32}.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// serial_addsub shared definitions.
// FSM state encoding and operation codes.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: one DIGIT-bit adder slice.
// Also exposes the carry into its MSB for overflow.
module addsub_digit #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] t;

   // add the slice; carry into MSB recovered from sum ^ x ^ y
   always_comb begin
      t    = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
      sum  = t[DIGIT-1:0];
      cout = t[DIGIT];
      cmsb = sum[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
   end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/sub, DIGIT bits per clock.
// LSB digit first; start/done handshake with C/V/Z flags.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carryout_q, carryout_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;

   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic             dcmsb;
   logic [WIDTH-1:0] dsum_top;

   // operands shift right, so the live digit is always at bit 0
   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x    (a_q[DIGIT-1:0]),
      .y    (b_q[DIGIT-1:0]),
      .cin  (carry_q),
      .sum  (dsum),
      .cout (dcout),
      .cmsb (dcmsb)
   );

   // next-state, datapath and flag update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      carry_d    = carry_q;
      result_d   = result_q;
      carryout_d = carryout_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      dsum_top   = WIDTH'(dsum) << (WIDTH - DIGIT);

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = S_BUSY;
               a_d      = a;
               b_d      = (op == OP_SUB) ? ~b : b;
               carry_d  = op;
               cnt_d    = '0;
               result_d = '0;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            // digits enter at the top; after N shifts digit i sits at i
            result_d = (result_q >> DIGIT) | dsum_top;
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            carry_d  = dcout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d    = S_DONE;
               carryout_d = dcout;
               overflow_d = dcmsb ^ dcout;
               zero_d     = (result_d == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         carry_q    <= 1'b0;
         result_q   <= '0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         carry_q    <= carry_d;
         result_q   <= result_d;
         carryout_q <= carryout_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
   assign done     = (state_q == S_DONE);
   assign result   = result_q;
   assign carryout = carryout_q;
   assign overflow = overflow_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: four DIGIT variants of serial_addsub
// against a plain-arithmetic reference model.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  st;
   logic        op;
   logic [31:0] a, b;
   logic [3:0]  rdy, dn, co, ov, zr;
   logic [31:0] res [4];

   int tests = 0;
   int fails = 0;
   int dcnt [4];

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(32), .DIGIT(8)) u_d8 (
      .clk(clk), .reset(reset), .start(st[0]), .op(op), .a(a), .b(b),
      .ready(rdy[0]), .done(dn[0]), .result(res[0]),
      .carryout(co[0]), .overflow(ov[0]), .zero(zr[0]));

   serial_addsub #(.WIDTH(32), .DIGIT(1)) u_d1 (
      .clk(clk), .reset(reset), .start(st[1]), .op(op), .a(a), .b(b),
      .ready(rdy[1]), .done(dn[1]), .result(res[1]),
      .carryout(co[1]), .overflow(ov[1]), .zero(zr[1]));

   serial_addsub #(.WIDTH(32), .DIGIT(4)) u_d4 (
      .clk(clk), .reset(reset), .start(st[2]), .op(op), .a(a), .b(b),
      .ready(rdy[2]), .done(dn[2]), .result(res[2]),
      .carryout(co[2]), .overflow(ov[2]), .zero(zr[2]));

   serial_addsub #(.WIDTH(32), .DIGIT(32)) u_d32 (
      .clk(clk), .reset(reset), .start(st[3]), .op(op), .a(a), .b(b),
      .ready(rdy[3]), .done(dn[3]), .result(res[3]),
      .carryout(co[3]), .overflow(ov[3]), .zero(zr[3]));

   always @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (dn[k]) dcnt[k] = dcnt[k] + 1;

   function automatic int n_of(int k);
      case (k)
         0: return 4;
         1: return 32;
         2: return 8;
         default: return 1;
      endcase
   endfunction

   // reference: {carryout, overflow, zero, result}
   function automatic logic [34:0] model(logic o, logic [31:0] x,
                                         logic [31:0] y);
      logic [32:0] s;
      logic [31:0] r;
      logic        v;
      if (o) s = {1'b0, x} + {1'b0, ~y} + 33'd1;
      else   s = {1'b0, x} + {1'b0, y};
      r = s[31:0];
      if (o) v = (x[31] != y[31]) && (r[31] != x[31]);
      else   v = (x[31] == y[31]) && (r[31] != x[31]);
      return {s[32], v, (r == 32'd0), r};
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(int k);
      int n = 0;
      while (!rdy[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[k]) check("ready_timeout", 64'(rdy[k]), 64'd1);
   endtask

   // waits for done on instance k, checks latency and all outputs
   task automatic finish_op(int k, int lat0, logic [34:0] m,
                            string tag, output logic [31:0] r);
      int lat = lat0;
      while (!dn[k] && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(n_of(k)));
      check({tag, "_res"}, 64'(res[k]), 64'(m[31:0]));
      check({tag, "_co"}, 64'(co[k]), 64'(m[34]));
      check({tag, "_ov"}, 64'(ov[k]), 64'(m[33]));
      check({tag, "_zr"}, 64'(zr[k]), 64'(m[32]));
      check({tag, "_rdy"}, 64'(rdy[k]), 64'd1);
      r = res[k];
   endtask

   task automatic run_op(int k, logic o, logic [31:0] x, logic [31:0] y,
                         string tag, output logic [31:0] r);
      logic [34:0] m = model(o, x, y);
      wait_ready(k);
      op = o; a = x; b = y; st[k] = 1'b1;
      @(negedge clk);
      st[k] = 1'b0;
      op = 1'($urandom); a = $urandom; b = $urandom;
      finish_op(k, 0, m, tag, r);
      @(negedge clk);
      check({tag, "_pulse"}, 64'(dn[k]), 64'd0);
   endtask

   logic [31:0] r;
   int d0;

   initial begin
      st = '0; op = 1'b0; a = '0; b = '0;
      for (int k = 0; k < 4; k++) dcnt[k] = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("rst_ready", 64'(rdy[k]), 64'd1);
         check("rst_done", 64'(dn[k]), 64'd0);
         check("rst_res", 64'(res[k]), 64'd0);
         check("rst_flags", 64'({co[k], ov[k], zr[k]}), 64'd0);
      end

      run_op(0, 1'b1, 32'd8, 32'd9, "t1", r);
      check("t1_val", 64'(r), 64'hFFFFFFFF);
      run_op(0, 1'b1, 32'd11, 32'd1, "t2s", r);
      check("t2s_val", 64'(r), 64'd10);
      run_op(0, 1'b0, 32'd27, 32'd3, "t2a", r);
      check("t2a_val", 64'(r), 64'd30);
      run_op(0, 1'b0, 32'h7FFFFFFF, 32'd1, "t3a", r);
      check("t3a_val", 64'({ov[0], r}), {31'd0, 1'b1, 32'h80000000});
      run_op(0, 1'b1, 32'd5, 32'd5, "t3s", r);
      check("t3s_val", 64'({co[0], zr[0], r}), 64'h3_0000_0000);

      // start during BUSY is ignored; then back-to-back from DONE
      d0 = dcnt[0];
      op = 1'b0; a = 32'd100; b = 32'd200; st[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      op = 1'b1; a = 32'd1; b = 32'd2; st[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0;
      finish_op(0, 3, model(1'b0, 32'd100, 32'd200), "t4", r);
      op = 1'b0; a = 32'd7; b = 32'd8; st[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0;
      check("t4_b2b_rdy", 64'(rdy[0]), 64'd0);
      check("t4_once", 64'(dcnt[0] - d0), 64'd1);
      finish_op(0, 0, model(1'b0, 32'd7, 32'd8), "t4b", r);
      @(negedge clk);

      // reset mid-BUSY aborts without a done pulse
      op = 1'b0; a = 32'd55; b = 32'd66; st[0] = 1'b1;
      @(negedge clk); st[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_rdy", 64'(rdy[0]), 64'd1);
      check("t5_res", 64'(res[0]), 64'd0);
      check("t5_done", 64'(dn[0]), 64'd0);
      d0 = dcnt[0];
      repeat (8) @(negedge clk);
      check("t5_nodone", 64'(dcnt[0] - d0), 64'd0);
      run_op(0, 1'b0, 32'd1000, 32'd24, "t5f", r);

      run_op(1, 1'b1, 32'd11, 32'd2049, "t6", r);
      check("t6_val", 64'({co[1], r}), {31'd0, 1'b0, 32'hFFFFF80A});

      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 15; i++)
            run_op(k, 1'($urandom), $urandom, $urandom, "rnd", r);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
